// File: rtl/aes_round_iter_if.sv
// Handshake and key-lookup bundle around the iterative AES core.
// The core sits on the slave side; the block-level environment is the master.
interface aes_round_iter_if #(
    parameter int RKW = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [RKW-1:0] rk_idx;
    logic [127:0]   round_key;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic           busy;

    modport master (
        output in_valid, in_data, round_key, out_ready,
        input  in_ready, rk_idx, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, round_key, out_ready,
        output in_ready, rk_idx, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_round_iter.sv
// Iterative AES-128/192/256 encryption: initial AddRoundKey on accept, then one
// full round per clock around a single 128-bit state register.
module aes_round_iter #(
    parameter int NK  = 4,
    parameter int NR  = NK + 6,
    parameter int RKW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    aes_round_iter_if.slave bus
);
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("aes_round_iter: NK must be 4, 6 or 8");
    end
    if (NR != NK + 6 || (1 << RKW) <= NR) begin : g_bad_nr
        $error("aes_round_iter: NR must equal NK+6 and fit in RKW bits");
    end

    localparam logic [RKW-1:0] NR_W = RKW'(NR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [RKW-1:0] rnd_q, rnd_d;
    logic [127:0]   st_q, st_d;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    // S-box computed as x^254 (GF(2^8) inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [7:0]   sb [16];
    logic [7:0]   sr [16];
    logic [7:0]   mc [16];
    logic [127:0] sr_w, mc_w;

    // Byte k of the state lives at bits [127-8k -: 8]; byte index = row + 4*col.
    always_comb begin
        for (int k = 0; k < 16; k++) sb[k] = sbox(st_q[8*(15-k) +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
        end
        sr_w = '0;
        mc_w = '0;
        for (int k = 0; k < 16; k++) begin
            sr_w[8*(15-k) +: 8] = sr[k];
            mc_w[8*(15-k) +: 8] = mc[k];
        end
    end

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        unique case (state_q)
            IDLE: if (bus.in_valid) begin
                st_d    = bus.in_data ^ bus.round_key;
                rnd_d   = RKW'(1);
                state_d = RUN;
            end
            RUN: if (rnd_q == NR_W) begin
                st_d    = sr_w ^ bus.round_key;
                state_d = DONE;
            end else begin
                st_d  = mc_w ^ bus.round_key;
                rnd_d = rnd_q + RKW'(1);
            end
            DONE: if (bus.out_ready) begin
                rnd_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    // Outputs decode only registered state, so no handshake input reaches them.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_data  = st_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.rk_idx    = (state_q == RUN) ? rnd_q : '0;
endmodule

// File: tb/tb_aes_round_iter.sv
// Scoreboarded bench for aes_round_iter: three cores (NK=4/6/8) fed from a
// bench key-schedule model, checked against FIPS-197 / SP800-38A vectors.
module tb_aes_round_iter;
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] K0  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTV = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CTV = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic         iv   [3];
    logic [127:0] idat [3];
    logic         ordy [3];
    logic         irdy [3];
    logic         ov   [3];
    logic         bsy  [3];
    logic [127:0] odat [3];
    logic [3:0]   rki  [3];
    logic         ov_prev [3];
    logic [127:0] rks [3][16];
    logic [127:0] exp_q [3][$];
    int           acc_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gd
        aes_round_iter_if #(.RKW(4)) bus ();
        aes_round_iter #(.NK(4 + 2*g), .RKW(4)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus.slave)
        );
        assign bus.in_valid  = iv[g];
        assign bus.in_data   = idat[g];
        assign bus.out_ready = ordy[g];
        assign bus.round_key = rks[g][bus.rk_idx];
        assign irdy[g] = bus.in_ready;
        assign ov[g]   = bus.out_valid;
        assign odat[g] = bus.out_data;
        assign bsy[g]  = bus.busy;
        assign rki[g]  = bus.rk_idx;
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [7:0] sb(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8*int'(x) -: 8];
    endfunction

    task automatic expand(input int g, input int nk, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int          nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = {sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0]), sb(tmp[31:24])} ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = {sb(tmp[31:24]), sb(tmp[23:16]), sb(tmp[15:8]), sb(tmp[7:0])};
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++)
            rks[g][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Waits (bounded) for the g0 core to be ready; returns at the accepting edge + 1.
    task automatic wait_accept(output int t);
        t = -1;
        for (int n = 0; n < 40 && t < 0; n++) begin
            @(negedge clk);
            if (irdy[0]) t = cyc + 1;
        end
        if (t < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q[0].size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 128'(exp_q[0].size()), 128'd0);
    endtask

    // Monitor: latency on out_valid rise, data on each completed output handshake.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (iv[g] && irdy[g]) acc_q[g].push_back(cyc + 1);
            if (ov[g] && !ov_prev[g]) begin
                if (acc_q[g].size() == 0) chk("latency_no_accept", 128'd1, 128'd0);
                else chk("latency", 128'(cyc - acc_q[g].pop_front()), 128'(10 + 2*g));
            end
            if (ov[g] && ordy[g]) begin
                if (exp_q[g].size() == 0) chk("unexpected_output", odat[g], 128'hx);
                else chk("out_data", odat[g], exp_q[g].pop_front());
            end
            ov_prev[g] <= ov[g];
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2;
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            iv[g] = 1'b0; idat[g] = '0; ordy[g] = 1'b1; ov_prev[g] = 1'b0;
        end
        expand(0, 4, K0);
        expand(1, 6, K0);
        expand(2, 8, K0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_in_ready",  128'(irdy[0]), 128'd1);
        chk("rst_out_valid", 128'(ov[0]),   128'd0);
        chk("rst_out_data",  odat[0],       128'd0);
        chk("rst_busy",      128'(bsy[0]),  128'd0);
        chk("rst_rk_idx",    128'(rki[0]),  128'd0);

        // C.1 / C.2 / C.3 in parallel; g0 is then held in DONE for backpressure.
        @(posedge clk); #1;
        exp_q[0].push_back(C1);
        exp_q[1].push_back(C2);
        exp_q[2].push_back(C3);
        ordy[0] = 1'b0;
        for (int g = 0; g < 3; g++) begin iv[g] = 1'b1; idat[g] = PT; end
        @(negedge clk);
        chk("rk_idx_idle", 128'(rki[0]), 128'd0);
        @(posedge clk); #1;
        for (int g = 0; g < 3; g++) begin iv[g] = 1'b0; idat[g] = '0; end
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("rk_idx_run%0d", k), 128'(rki[0]), 128'(k));
        end
        @(negedge clk);
        chk("rk_idx_done", 128'(rki[0]), 128'd0);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_out_valid", 128'(ov[0]),   128'd1);
            chk("bp_out_data",  odat[0],       C1);
            chk("bp_in_ready",  128'(irdy[0]), 128'd0);
        end
        @(posedge clk); #1 ordy[0] = 1'b1;
        @(negedge clk);
        chk("xfer_out_valid", 128'(ov[0]), 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_xfer_out_valid", 128'(ov[0]),   128'd0);
        chk("post_xfer_in_ready",  128'(irdy[0]), 128'd1);
        chk("post_xfer_busy",      128'(bsy[0]),  128'd0);
        repeat (10) @(negedge clk);
        chk("nk6_nk8_drained", 128'(exp_q[1].size() + exp_q[2].size()), 128'd0);

        // Back-to-back blocks under a different AES-128 key.
        @(posedge clk); #1;
        expand(0, 4, {KB, 128'h0});
        exp_q[0].push_back(CTB);
        exp_q[0].push_back(CTV);
        iv[0] = 1'b1; idat[0] = PTB;
        wait_accept(t1);
        idat[0] = PTV;
        wait_accept(t2);
        iv[0] = 1'b0;
        chk("b2b_spacing", 128'(t2 - t1), 128'd12);
        wait_drain("b2b_drain");

        // Reset while rnd==5 discards the block; a fresh C.1 must still work.
        @(posedge clk); #1;
        expand(0, 4, K0);
        exp_q[0].push_back(C1);
        iv[0] = 1'b1; idat[0] = PT;
        wait_accept(t1);
        iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rk_idx_pre_reset", 128'(rki[0]), 128'd5);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_q[0].delete();
        acc_q[0].delete();
        @(negedge clk);
        chk("mid_rst_out_valid", 128'(ov[0]),   128'd0);
        chk("mid_rst_out_data",  odat[0],       128'd0);
        chk("mid_rst_in_ready",  128'(irdy[0]), 128'd1);
        chk("mid_rst_busy",      128'(bsy[0]),  128'd0);
        @(posedge clk); #1;
        exp_q[0].push_back(C1);
        iv[0] = 1'b1; idat[0] = PT;
        wait_accept(t1);
        iv[0] = 1'b0;
        wait_drain("post_reset_drain");

        repeat (5) @(negedge clk);
        for (int g = 0; g < 3; g++) chk("final_accept_q", 128'(acc_q[g].size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_round_iter.md
Name: aes_round_iter

Overview:
- Iterative AES-128/192/256 encryption datapath. Performs the initial AddRoundKey, then one full cipher round per clock.
- Reuses the existing SubBytes, shift_rows, MixColumns and AddRoundKey stages around a single 128-bit state register. The final round bypasses MixColumns.
- Round keys are fetched by index from an external key-schedule store through a combinational lookup.
- Sits between the block-level input/output handshakes and the key-schedule block.

Parameters:
- NK, 4, key length in 32-bit words. Legal values 4, 6, 8; any other value is an elaboration error.
- NR, NK+6, number of cipher rounds: 10, 12 or 14.
- RKW, 4, width of the round-key index. Must satisfy 2^RKW > NR.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  plaintext block offered.
- in_ready  out  1  core accepts a block this cycle.
- in_data  in  128  plaintext. Bit 127 is byte 0 (FIPS-197 order).
- rk_idx  out  RKW  round-key index requested this cycle.
- round_key  in  128  round key for rk_idx, valid in the same cycle (combinational lookup).
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer takes the ciphertext.
- out_data  out  128  ciphertext, same byte order as in_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Round counter rnd is RKW bits wide. State register st is 128 bits.
- Reset (rst_n low at a clock edge): FSM returns to IDLE, rnd=0, st=0. After reset, in_ready=1, out_valid=0, out_data=0, busy=0 and rk_idx=0.
- Reset is honoured in every state. A reset in RUN or DONE discards the block in flight; no output is produced for it.
- IDLE:
  - in_ready=1, rk_idx=0.
  - On in_valid: st <= in_data ^ round_key, rnd <= 1, go to RUN.
- RUN:
  - in_ready=0, rk_idx=rnd.
  - If rnd<NR: st <= AddRoundKey(MixColumns(shift_rows(SubBytes(st))), round_key), rnd <= rnd+1.
  - If rnd==NR: st <= shift_rows(SubBytes(st)) ^ round_key, go to DONE.
- DONE:
  - out_valid=1, out_data=st, in_ready=0, rk_idx=0.
  - out_data stays stable while out_ready=0; stalls are unbounded.
  - On out_ready: go to IDLE, rnd <= 0. out_valid drops on the next cycle.
- Latency: a block accepted at edge T makes out_valid high after edge T+NR, i.e. NR cycles later (10/12/14).
- Throughput: at most one block per NR+2 cycles. No overlap; in_ready is low from acceptance until the output is consumed.
- in_data and round_key are ignored outside their sampling conditions.
- out_data is driven from st in every state.
- rk_idx never exceeds NR.
- The counter never wraps, because rnd is cleared on exit from DONE.
- All outputs are registered or decoded from FSM state only. There is no combinational path from in_valid or out_ready to any output.

Test Plan:
- NK=4, FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f via bench key-schedule model, plaintext 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 10 cycles after acceptance; rk_idx sequence 0,1..10.
- NK=6, FIPS-197 C.2: key 000102…1617, same plaintext -> dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles.
- NK=8, FIPS-197 C.3: key 000102…1e1f, same plaintext -> 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable and in_ready=0 throughout. Raise out_ready -> one-cycle transfer, then IDLE with in_ready=1.
- Back-to-back: in_valid held high with two blocks queued and out_ready=1 -> the second block is accepted exactly NR+2 cycles after the first, and both ciphertexts are correct.
- Mid-operation reset: rst_n=0 for one cycle at rnd=5 -> next cycle IDLE, out_valid=0, out_data=0. A following C.1 vector still produces the correct result.
